// File: rtl/mem_ref_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_ref_sequencer_if
//  Description : Bundles the sequencer's handshake inputs (run, stall, ir_op)
//                and its Mini-SRC datapath control outputs.
//                master : drives run/stall/ir_op, observes strobes/status.
//                slave  : the sequencer itself.
//  Ports       : run, stall, ir_op[OPC_W]           (master -> slave)
//                18 control strobes, state[4],
//                busy, done, illegal                (slave -> master)
//  Revision    : 1.0  initial release
// ============================================================================
interface mem_ref_sequencer_if #(
    parameter int OPC_W = 5
);
    logic             run;
    logic             stall;
    logic [OPC_W-1:0] ir_op;

    logic PCout, MARin, IncPC, PCin;
    logic Read, Write, MDRin, MDRout, IRin;
    logic Grb, BAout, Yin, Cout, Zlowin, Zlowout;
    logic Gra, Rin, Rout;

    logic [3:0] state;
    logic       busy;
    logic       done;
    logic       illegal;

    modport master (
        output run, stall, ir_op,
        input  PCout, MARin, IncPC, PCin, Read, Write, MDRin, MDRout, IRin,
               Grb, BAout, Yin, Cout, Zlowin, Zlowout, Gra, Rin, Rout,
               state, busy, done, illegal
    );

    modport slave (
        input  run, stall, ir_op,
        output PCout, MARin, IncPC, PCin, Read, Write, MDRin, MDRout, IRin,
               Grb, BAout, Yin, Cout, Zlowin, Zlowout, Gra, Rin, Rout,
               state, busy, done, illegal
    );
endinterface
`default_nettype wire

// File: rtl/mem_ref_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mem_ref_sequencer
//  Description : Moore control-step sequencer for the Mini-SRC memory-reference
//                instructions ld / ldi / st. Steps IDLE,T0..T7 with
//                configurable memory wait states, stall, auto-run and
//                illegal-opcode detection.
//  Ports       : clock   - system clock, rising edge
//                clear   - synchronous active-high reset
//                bus     - mem_ref_sequencer_if.slave (run, stall, ir_op in;
//                          control strobes, state, busy, done, illegal out)
//  Revision    : 1.0  initial release
// ============================================================================
module mem_ref_sequencer #(
    parameter int               OPC_W    = 5,
    parameter int               MEM_WAIT = 0,
    parameter int               WAIT_W   = 4,
    parameter logic [OPC_W-1:0] OP_LD    = OPC_W'(0),
    parameter logic [OPC_W-1:0] OP_LDI   = OPC_W'(1),
    parameter logic [OPC_W-1:0] OP_ST    = OPC_W'(2),
    parameter bit               AUTO_RUN = 1'b1
) (
    input  wire logic          clock,
    input  wire logic          clear,
    mem_ref_sequencer_if.slave bus
);

    localparam logic [3:0] c_ST_IDLE = 4'd0;
    localparam logic [3:0] c_ST_T0   = 4'd1;
    localparam logic [3:0] c_ST_T1   = 4'd2;
    localparam logic [3:0] c_ST_T2   = 4'd3;
    localparam logic [3:0] c_ST_T3   = 4'd4;
    localparam logic [3:0] c_ST_T4   = 4'd5;
    localparam logic [3:0] c_ST_T5   = 4'd6;
    localparam logic [3:0] c_ST_T6   = 4'd7;
    localparam logic [3:0] c_ST_T7   = 4'd8;

    localparam logic [WAIT_W-1:0] c_MEM_WAIT = WAIT_W'(MEM_WAIT);

    // Bit positions inside the packed strobe vector
    localparam int c_B_PCOUT   = 17;
    localparam int c_B_MARIN   = 16;
    localparam int c_B_INCPC   = 15;
    localparam int c_B_PCIN    = 14;
    localparam int c_B_READ    = 13;
    localparam int c_B_WRITE   = 12;
    localparam int c_B_MDRIN   = 11;
    localparam int c_B_MDROUT  = 10;
    localparam int c_B_IRIN    = 9;
    localparam int c_B_GRB     = 8;
    localparam int c_B_BAOUT   = 7;
    localparam int c_B_YIN     = 6;
    localparam int c_B_COUT    = 5;
    localparam int c_B_ZLOWIN  = 4;
    localparam int c_B_ZLOWOUT = 3;
    localparam int c_B_GRA     = 2;
    localparam int c_B_RIN     = 1;
    localparam int c_B_ROUT    = 0;

    logic [3:0]        state_q, state_d;
    logic [WAIT_W-1:0] wait_q,  wait_d;

    logic        w_is_ld, w_is_ldi, w_is_st, w_legal;
    logic        w_mem_step, w_wait_last, w_step_exit;
    logic [3:0]  w_after_final;
    logic [17:0] w_strobes;
    logic        w_done, w_illegal;

    assign w_is_ld  = (bus.ir_op == OP_LD);
    assign w_is_ldi = (bus.ir_op == OP_LDI);
    assign w_is_st  = (bus.ir_op == OP_ST);
    assign w_legal  = w_is_ld | w_is_ldi | w_is_st;

    // Past T5 only the ld path is told apart; anything else follows the st path.
    assign w_mem_step  = (state_q == c_ST_T1)
                       | ((state_q == c_ST_T6) &  w_is_ld)
                       | ((state_q == c_ST_T7) & ~w_is_ld);
    assign w_wait_last = (wait_q == c_MEM_WAIT);
    assign w_step_exit = ~w_mem_step | w_wait_last;

    assign w_after_final = (AUTO_RUN && bus.run) ? c_ST_T0 : c_ST_IDLE;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= c_ST_IDLE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (!bus.stall) begin
            case (state_q)
                c_ST_IDLE: if (bus.run) state_d = c_ST_T0;
                c_ST_T0:   state_d = c_ST_T1;
                c_ST_T1:   if (w_step_exit) state_d = c_ST_T2;
                c_ST_T2:   state_d = c_ST_T3;
                c_ST_T3:   state_d = w_legal ? c_ST_T4 : c_ST_IDLE;
                c_ST_T4:   state_d = c_ST_T5;
                c_ST_T5:   state_d = w_is_ldi ? w_after_final : c_ST_T6;
                c_ST_T6:   if (w_step_exit) state_d = c_ST_T7;
                c_ST_T7:   if (w_step_exit) state_d = w_after_final;
                default:   state_d = c_ST_IDLE;
            endcase
        end
    end

    // Wait counter: cleared on any step change, advances only while a
    // memory step is being held, frozen by stall.
    always_comb begin
        wait_d = wait_q;
        if (!bus.stall) begin
            if (state_d != state_q)
                wait_d = '0;
            else if (w_mem_step)
                wait_d = wait_q + WAIT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_strobes = '0;
        w_done    = 1'b0;
        w_illegal = 1'b0;
        case (state_q)
            c_ST_T0: begin
                w_strobes[c_B_PCOUT] = 1'b1;
                w_strobes[c_B_MARIN] = 1'b1;
                w_strobes[c_B_INCPC] = 1'b1;
                w_strobes[c_B_PCIN]  = 1'b1;
            end
            c_ST_T1: begin
                w_strobes[c_B_READ]  = 1'b1;
                w_strobes[c_B_MDRIN] = 1'b1;
            end
            c_ST_T2: begin
                w_strobes[c_B_MDROUT] = 1'b1;
                w_strobes[c_B_IRIN]   = 1'b1;
            end
            c_ST_T3: begin
                if (w_legal) begin
                    w_strobes[c_B_GRB]   = 1'b1;
                    w_strobes[c_B_BAOUT] = 1'b1;
                    w_strobes[c_B_YIN]   = 1'b1;
                end else begin
                    w_illegal = 1'b1;
                end
            end
            c_ST_T4: begin
                w_strobes[c_B_COUT]   = 1'b1;
                w_strobes[c_B_ZLOWIN] = 1'b1;
            end
            c_ST_T5: begin
                w_strobes[c_B_ZLOWOUT] = 1'b1;
                if (w_is_ldi) begin
                    w_strobes[c_B_GRA] = 1'b1;
                    w_strobes[c_B_RIN] = 1'b1;
                    w_done             = 1'b1;
                end else begin
                    w_strobes[c_B_MARIN] = 1'b1;
                end
            end
            c_ST_T6: begin
                w_strobes[c_B_MDRIN] = 1'b1;
                if (w_is_ld) begin
                    w_strobes[c_B_READ] = 1'b1;
                end else begin
                    w_strobes[c_B_GRA]  = 1'b1;
                    w_strobes[c_B_ROUT] = 1'b1;
                end
            end
            c_ST_T7: begin
                if (w_is_ld) begin
                    w_strobes[c_B_MDROUT] = 1'b1;
                    w_strobes[c_B_GRA]    = 1'b1;
                    w_strobes[c_B_RIN]    = 1'b1;
                    w_done                = 1'b1;
                end else begin
                    w_strobes[c_B_WRITE] = 1'b1;
                    w_done               = w_wait_last;
                end
            end
            default: ;
        endcase
        // A held step must not repeat its side effects; the illegal pulse is
        // gated too so it stays a single cycle even if T3 is stalled.
        if (bus.stall) begin
            w_strobes = '0;
            w_done    = 1'b0;
            w_illegal = 1'b0;
        end
    end

    assign {bus.PCout, bus.MARin, bus.IncPC, bus.PCin, bus.Read, bus.Write,
            bus.MDRin, bus.MDRout, bus.IRin, bus.Grb, bus.BAout, bus.Yin,
            bus.Cout, bus.Zlowin, bus.Zlowout, bus.Gra, bus.Rin, bus.Rout} = w_strobes;

    assign bus.state   = state_q;
    assign bus.busy    = (state_q != c_ST_IDLE);
    assign bus.done    = w_done;
    assign bus.illegal = w_illegal;

endmodule
`default_nettype wire

// File: tb/tb_mem_ref_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_ref_sequencer
//  Description : Directed self-checking bench for mem_ref_sequencer. Three
//                instances (MEM_WAIT = 0, 3, 2) share clock, clear and
//                stimulus; each test observes the instance it targets.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_ref_sequencer;

    localparam logic [17:0] PCOUT   = 18'h20000;
    localparam logic [17:0] MARIN   = 18'h10000;
    localparam logic [17:0] INCPC   = 18'h08000;
    localparam logic [17:0] PCIN    = 18'h04000;
    localparam logic [17:0] READ    = 18'h02000;
    localparam logic [17:0] WRITE   = 18'h01000;
    localparam logic [17:0] MDRIN   = 18'h00800;
    localparam logic [17:0] MDROUT  = 18'h00400;
    localparam logic [17:0] IRIN    = 18'h00200;
    localparam logic [17:0] GRB     = 18'h00100;
    localparam logic [17:0] BAOUT   = 18'h00080;
    localparam logic [17:0] YIN     = 18'h00040;
    localparam logic [17:0] COUT    = 18'h00020;
    localparam logic [17:0] ZLOWIN  = 18'h00010;
    localparam logic [17:0] ZLOWOUT = 18'h00008;
    localparam logic [17:0] GRA     = 18'h00004;
    localparam logic [17:0] RIN     = 18'h00002;
    localparam logic [17:0] ROUT    = 18'h00001;

    localparam logic [17:0] S_NONE = 18'h0;
    localparam logic [17:0] S_T0   = PCOUT | MARIN | INCPC | PCIN;
    localparam logic [17:0] S_RD   = READ | MDRIN;
    localparam logic [17:0] S_T2   = MDROUT | IRIN;
    localparam logic [17:0] S_T3   = GRB | BAOUT | YIN;
    localparam logic [17:0] S_T4   = COUT | ZLOWIN;
    localparam logic [17:0] S_T5I  = ZLOWOUT | GRA | RIN;
    localparam logic [17:0] S_T5   = ZLOWOUT | MARIN;
    localparam logic [17:0] S_T6S  = GRA | ROUT | MDRIN;
    localparam logic [17:0] S_T7L  = MDROUT | GRA | RIN;
    localparam logic [17:0] S_T7S  = WRITE;

    localparam logic [4:0] OP_LD  = 5'b00000;
    localparam logic [4:0] OP_LDI = 5'b00001;
    localparam logic [4:0] OP_ST  = 5'b00010;
    localparam logic [4:0] OP_BAD = 5'b01111;

    logic       clock = 1'b0;
    logic       clear;
    logic       run;
    logic       stall;
    logic [4:0] ir_op;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    mem_ref_sequencer_if #(.OPC_W(5)) bus0 ();
    mem_ref_sequencer_if #(.OPC_W(5)) bus1 ();
    mem_ref_sequencer_if #(.OPC_W(5)) bus2 ();

    assign bus0.run = run;  assign bus0.stall = stall;  assign bus0.ir_op = ir_op;
    assign bus1.run = run;  assign bus1.stall = stall;  assign bus1.ir_op = ir_op;
    assign bus2.run = run;  assign bus2.stall = stall;  assign bus2.ir_op = ir_op;

    mem_ref_sequencer #(.MEM_WAIT(0)) u_dut0 (.clock(clock), .clear(clear), .bus(bus0));
    mem_ref_sequencer #(.MEM_WAIT(3)) u_dut1 (.clock(clock), .clear(clear), .bus(bus1));
    mem_ref_sequencer #(.MEM_WAIT(2)) u_dut2 (.clock(clock), .clear(clear), .bus(bus2));

    // Observed vector: {state, 18 strobes, busy, done, illegal}
    logic [24:0] obs [3];
    assign obs[0] = {bus0.state, bus0.PCout, bus0.MARin, bus0.IncPC, bus0.PCin,
                     bus0.Read, bus0.Write, bus0.MDRin, bus0.MDRout, bus0.IRin,
                     bus0.Grb, bus0.BAout, bus0.Yin, bus0.Cout, bus0.Zlowin,
                     bus0.Zlowout, bus0.Gra, bus0.Rin, bus0.Rout,
                     bus0.busy, bus0.done, bus0.illegal};
    assign obs[1] = {bus1.state, bus1.PCout, bus1.MARin, bus1.IncPC, bus1.PCin,
                     bus1.Read, bus1.Write, bus1.MDRin, bus1.MDRout, bus1.IRin,
                     bus1.Grb, bus1.BAout, bus1.Yin, bus1.Cout, bus1.Zlowin,
                     bus1.Zlowout, bus1.Gra, bus1.Rin, bus1.Rout,
                     bus1.busy, bus1.done, bus1.illegal};
    assign obs[2] = {bus2.state, bus2.PCout, bus2.MARin, bus2.IncPC, bus2.PCin,
                     bus2.Read, bus2.Write, bus2.MDRin, bus2.MDRout, bus2.IRin,
                     bus2.Grb, bus2.BAout, bus2.Yin, bus2.Cout, bus2.Zlowin,
                     bus2.Zlowout, bus2.Gra, bus2.Rin, bus2.Rout,
                     bus2.busy, bus2.done, bus2.illegal};

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (state/strobes/busy/done/illegal)", tag, act, exp);
        end
    endtask

    // Inputs for the cycle are set before the call; outputs are sampled on
    // the falling edge, then time advances to just after the next rising edge.
    task automatic cyc(input string tag, input int dut, input logic [3:0] st,
                       input logic [17:0] sb, input logic dn, input logic il);
        logic [31:0] exp_v;
        exp_v = {7'd0, st, sb, (st != 4'd0), dn, il};
        @(negedge clock);
        check_val(tag, {7'd0, obs[dut]}, exp_v);
        @(posedge clock);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        run   = 1'b0;
        stall = 1'b0;
        @(posedge clock);
        #1;
        clear = 1'b0;
    endtask

    initial begin
        clear = 1'b1;
        run   = 1'b0;
        stall = 1'b0;
        ir_op = OP_LD;
        @(posedge clock); #1;
        @(posedge clock); #1;
        cyc("rst_d0", 0, 4'd0, S_NONE, 1'b0, 1'b0);
        cyc("rst_d1", 1, 4'd0, S_NONE, 1'b0, 1'b0);
        cyc("rst_d2", 2, 4'd0, S_NONE, 1'b0, 1'b0);

        // ld, MEM_WAIT=0: eight consecutive steps, done in T7
        clear = 1'b0;
        run   = 1'b1;
        cyc("ld_idle", 0, 4'd0, S_NONE, 1'b0, 1'b0);
        run = 1'b0;
        cyc("ld_t0", 0, 4'd1, S_T0,  1'b0, 1'b0);
        cyc("ld_t1", 0, 4'd2, S_RD,  1'b0, 1'b0);
        cyc("ld_t2", 0, 4'd3, S_T2,  1'b0, 1'b0);
        cyc("ld_t3", 0, 4'd4, S_T3,  1'b0, 1'b0);
        cyc("ld_t4", 0, 4'd5, S_T4,  1'b0, 1'b0);
        cyc("ld_t5", 0, 4'd6, S_T5,  1'b0, 1'b0);
        cyc("ld_t6", 0, 4'd7, S_RD,  1'b0, 1'b0);
        cyc("ld_t7", 0, 4'd8, S_T7L, 1'b1, 1'b0);
        cyc("ld_end", 0, 4'd0, S_NONE, 1'b0, 1'b0);

        // ldi, run pulsed once: T0..T5 then IDLE
        do_clear();
        ir_op = OP_LDI;
        run   = 1'b1;
        cyc("ldi_idle", 0, 4'd0, S_NONE, 1'b0, 1'b0);
        run = 1'b0;
        cyc("ldi_t0", 0, 4'd1, S_T0,  1'b0, 1'b0);
        cyc("ldi_t1", 0, 4'd2, S_RD,  1'b0, 1'b0);
        cyc("ldi_t2", 0, 4'd3, S_T2,  1'b0, 1'b0);
        cyc("ldi_t3", 0, 4'd4, S_T3,  1'b0, 1'b0);
        cyc("ldi_t4", 0, 4'd5, S_T4,  1'b0, 1'b0);
        cyc("ldi_t5", 0, 4'd6, S_T5I, 1'b1, 1'b0);
        cyc("ldi_end0", 0, 4'd0, S_NONE, 1'b0, 1'b0);
        cyc("ldi_end1", 0, 4'd0, S_NONE, 1'b0, 1'b0);

        // st, MEM_WAIT=3: memory steps held 4 cycles, 14 cycles total
        do_clear();
        ir_op = OP_ST;
        run   = 1'b1;
        cyc("st_idle", 1, 4'd0, S_NONE, 1'b0, 1'b0);
        run = 1'b0;
        cyc("st_t0", 1, 4'd1, S_T0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            cyc($sformatf("st_t1_%0d", i), 1, 4'd2, S_RD, 1'b0, 1'b0);
        cyc("st_t2", 1, 4'd3, S_T2,  1'b0, 1'b0);
        cyc("st_t3", 1, 4'd4, S_T3,  1'b0, 1'b0);
        cyc("st_t4", 1, 4'd5, S_T4,  1'b0, 1'b0);
        cyc("st_t5", 1, 4'd6, S_T5,  1'b0, 1'b0);
        cyc("st_t6", 1, 4'd7, S_T6S, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            cyc($sformatf("st_t7_%0d", i), 1, 4'd8, S_T7S, (i == 3), 1'b0);
        cyc("st_end", 1, 4'd0, S_NONE, 1'b0, 1'b0);

        // unsupported opcode: illegal pulse in T3, no T3 strobes, back to IDLE
        do_clear();
        ir_op = OP_BAD;
        run   = 1'b1;
        cyc("ill_idle", 0, 4'd0, S_NONE, 1'b0, 1'b0);
        run = 1'b0;
        cyc("ill_t0", 0, 4'd1, S_T0,   1'b0, 1'b0);
        cyc("ill_t1", 0, 4'd2, S_RD,   1'b0, 1'b0);
        cyc("ill_t2", 0, 4'd3, S_T2,   1'b0, 1'b0);
        cyc("ill_t3", 0, 4'd4, S_NONE, 1'b0, 1'b1);
        cyc("ill_end", 0, 4'd0, S_NONE, 1'b0, 1'b0);

        // stall during second cycle of T1 (MEM_WAIT=2)
        do_clear();
        ir_op = OP_LD;
        run   = 1'b1;
        cyc("stl_idle", 2, 4'd0, S_NONE, 1'b0, 1'b0);
        run = 1'b0;
        cyc("stl_t0",  2, 4'd1, S_T0, 1'b0, 1'b0);
        cyc("stl_t1a", 2, 4'd2, S_RD, 1'b0, 1'b0);
        stall = 1'b1;
        for (int i = 0; i < 3; i++)
            cyc($sformatf("stl_hold_%0d", i), 2, 4'd2, S_NONE, 1'b0, 1'b0);
        stall = 1'b0;
        cyc("stl_t1b", 2, 4'd2, S_RD, 1'b0, 1'b0);
        cyc("stl_t1c", 2, 4'd2, S_RD, 1'b0, 1'b0);
        cyc("stl_t2",  2, 4'd3, S_T2, 1'b0, 1'b0);

        // stall in IDLE blocks the start
        do_clear();
        stall = 1'b1;
        run   = 1'b1;
        cyc("stl_idle0", 0, 4'd0, S_NONE, 1'b0, 1'b0);
        cyc("stl_idle1", 0, 4'd0, S_NONE, 1'b0, 1'b0);
        stall = 1'b0;
        cyc("stl_idle2", 0, 4'd0, S_NONE, 1'b0, 1'b0);
        run = 1'b0;
        cyc("stl_start", 0, 4'd1, S_T0, 1'b0, 1'b0);

        // auto-run back-to-back ld, then clear in T4 of the second
        do_clear();
        ir_op = OP_LD;
        run   = 1'b1;
        cyc("ar_idle", 0, 4'd0, S_NONE, 1'b0, 1'b0);
        cyc("ar_t0",   0, 4'd1, S_T0,  1'b0, 1'b0);
        cyc("ar_t1",   0, 4'd2, S_RD,  1'b0, 1'b0);
        cyc("ar_t2",   0, 4'd3, S_T2,  1'b0, 1'b0);
        cyc("ar_t3",   0, 4'd4, S_T3,  1'b0, 1'b0);
        cyc("ar_t4",   0, 4'd5, S_T4,  1'b0, 1'b0);
        cyc("ar_t5",   0, 4'd6, S_T5,  1'b0, 1'b0);
        cyc("ar_t6",   0, 4'd7, S_RD,  1'b0, 1'b0);
        cyc("ar_t7",   0, 4'd8, S_T7L, 1'b1, 1'b0);
        cyc("ar_t0b",  0, 4'd1, S_T0,  1'b0, 1'b0);
        cyc("ar_t1b",  0, 4'd2, S_RD,  1'b0, 1'b0);
        cyc("ar_t2b",  0, 4'd3, S_T2,  1'b0, 1'b0);
        cyc("ar_t3b",  0, 4'd4, S_T3,  1'b0, 1'b0);
        clear = 1'b1;
        cyc("ar_t4b",  0, 4'd5, S_T4,  1'b0, 1'b0);
        clear = 1'b0;
        run   = 1'b0;
        cyc("ar_clr0", 0, 4'd0, S_NONE, 1'b0, 1'b0);
        cyc("ar_clr1", 0, 4'd0, S_NONE, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
